counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the counter (2..8).
REQ-002 Parameter WIDTH, default 4: counter width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  bit i: requester i presents a command.
REQ-006 req_op  input  2*NUM_REQ  op of requester i in bits [2i+1:2i]: 00 READ, 01 INC, 10 DEC, 11 LOAD.
REQ-007 req_data  input  WIDTH*NUM_REQ  LOAD value of requester i in bits [WIDTH*(i+1)-1:WIDTH*i].
REQ-008 clear  input  1  request to zero the counter; priority over all requesters.
REQ-009 req_ready  output  NUM_REQ  one-hot (or zero) acceptance; command i accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 count  output  WIDTH  current shared counter value.
REQ-011 rsp_valid  output  1  one-cycle pulse: command completed.
REQ-012 rsp_id  output  clog2(NUM_REQ)  index of completed requester; valid with rsp_valid.
REQ-013 rsp_count  output  WIDTH  counter value after the completed op; valid with rsp_valid.
REQ-014 wrap  output  1  one-cycle pulse with rsp_valid when the op overflowed or underflowed.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; each op occupies exactly 3 cycles (max throughput one op per 3 cycles).
REQ-016 IDLE: if clear is high, count SHALL become 0 on that edge, no requester accepted, state stays IDLE.
REQ-017 IDLE, clear low, any req_valid high: round-robin winner chosen starting at pointer; req_ready[winner] high that cycle only; winner index, op, data latched; next state EXEC.
REQ-018 req_ready SHALL be zero in EXEC and RESP and whenever no req_valid bit is high.
REQ-019 EXEC: latched op applied to count — READ no change; INC count+1; DEC count-1; LOAD count=data; next state RESP.
REQ-020 Arithmetic modulo 2^WIDTH: INC at all-ones gives 0 with wrap; DEC at 0 gives all-ones with wrap; LOAD and READ never set wrap.
REQ-021 RESP: rsp_valid=1, rsp_id=latched winner, rsp_count=count, wrap as computed; pointer = (winner+1) mod NUM_REQ; next state IDLE.
REQ-022 clear asserted in EXEC or RESP SHALL be ignored; it takes effect only if still high in IDLE.
REQ-023 Requester dropping req_valid before acceptance: no command issued, no response, pointer unchanged.
REQ-024 Requester SHALL keep op/data stable while valid; block samples them only in the acceptance cycle.
REQ-025 Round-robin: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0 with no starvation.
REQ-026 count output SHALL change only on the EXEC->RESP edge, on clear in IDLE, or on reset.

Reset
REQ-027 reset high at a rising edge: state IDLE, count 0, pointer 0, latched winner/op/data 0.
REQ-028 During and after reset: req_ready 0, rsp_valid 0, rsp_id 0, rsp_count 0, wrap 0.
REQ-029 Reset mid-operation (EXEC or RESP) SHALL abandon the op with no response issued.
REQ-030 reset SHALL take priority over clear and all requests.

Structure
REQ-031 Shared package cnt_arb_pkg SHALL hold the op encoding constants (READ/INC/DEC/LOAD) and the FSM state typedef.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, grant index, any).
REQ-033 Counter register, FSM, and pointer live in counter_arbiter.

Verification
REQ-034 Reset, then requester 2 INC -> req_ready=0100 in acceptance cycle; two cycles later rsp_valid, rsp_id=2, rsp_count=1, wrap=0.
REQ-035 LOAD 4'hF from requester 0, then INC from requester 1 -> rsp_count=0, wrap=1; then DEC from requester 3 -> rsp_count=4'hF, wrap=1.
REQ-036 All four valid with INC continuously from count 0 -> grant order 0,1,2,3,0; rsp_count 1,2,3,4,5; one grant every 3 cycles.
REQ-037 clear asserted during EXEC of requester 1 LOAD 4'h9 -> rsp_count=9; clear still high in IDLE -> count=0, no grant that cycle.
REQ-038 Reset asserted in EXEC of INC at count=5 -> no rsp_valid, count=0, next grant starts at requester 0.
REQ-039 Requester 1 valid for one IDLE cycle with requester 0 winning, then drops -> only requester 0 responds; pointer advances to 1.

Source files
------------

// File: rtl/cnt_arb_pkg.sv
// Shared definitions for the arbitrated counter: op encoding and FSM states.
package cnt_arb_pkg;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first asserted request at or after ptr_i,
// wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IW-1:0];
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shared counter arbitrated among NUM_REQ requesters; every command takes
// three cycles: accept, apply, respond.
//
// state | meaning
// IDLE  | honour clear, otherwise accept the round-robin winner
// EXEC  | apply the latched op to the counter and capture wrap
// RESP  | present the response, move the pointer past the winner
module counter_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  WIDTH   = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  input  logic                     clear,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         count,
  output logic                     rsp_valid,
  output logic [IW-1:0]            rsp_id,
  output logic [WIDTH-1:0]         rsp_count,
  output logic                     wrap
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               wrap_q, wrap_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // One-hot grant selects the winner's op and data slice.
  always_comb begin
    sel_op   = OP_READ;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_READ;
      data_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      data_q  <= data_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    data_d  = data_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (gnt_any) begin
          win_d   = gnt_idx;
          op_d    = sel_op;
          data_d  = sel_data;
          wrap_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // clear is deliberately not looked at here or in RESP
        case (op_q)
          OP_INC: begin
            count_d = count_q + WIDTH'(1);
            wrap_d  = &count_q;
          end
          OP_DEC: begin
            count_d = count_q - WIDTH'(1);
            wrap_d  = ~|count_q;
          end
          OP_LOAD: begin
            count_d = data_q;
            wrap_d  = 1'b0;
          end
          default: begin
            wrap_d  = 1'b0;
          end
        endcase
        state_d = RESP;
      end
      RESP: begin
        ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_count = '0;
    wrap      = 1'b0;
    if (!reset) begin
      if (state_q == IDLE && !clear) req_ready = gnt;
      if (state_q == RESP) begin
        rsp_valid = 1'b1;
        rsp_id    = win_q;
        rsp_count = count_q;
        wrap      = wrap_q;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Randomized and directed bench for counter_arbiter against a transaction-level
// model that schedules each accepted command's effects by cycle offset.
module tb_counter_arbiter;

  localparam int N = 4;
  localparam int W = 4;
  localparam int MODV = 1 << W;

  logic           clk = 1'b0;
  logic           reset;
  logic           clear;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   count;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_count;
  logic           wrap;

  counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .clear     (clear),
    .req_ready (req_ready),
    .count     (count),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: committed count/pointer plus at most one in-flight command
  int m_count, m_ptr, cyc, acc_cyc, p_id, p_count;
  bit pend, p_wrap;

  logic [N-1:0] obs_ready;
  logic         obs_rsp_valid, obs_wrap;
  logic [1:0]   obs_id;
  logic [W-1:0] obs_count, obs_rsp_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic [N-1:0] v,
                      input logic [2*N-1:0] op, input logic [W*N-1:0] d);
    int win, idx, opc, dat;
    bit found, exp_rsp;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    reset     = rst;
    clear     = clr;
    req_valid = v;
    req_op    = op;
    req_data  = d;
    #1;
    if (pend && cyc == acc_cyc + 3) begin
      m_ptr = (p_id + 1) % N;
      pend  = 1'b0;
    end
    if (pend && cyc == acc_cyc + 2) m_count = p_count;
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!found && v[idx[1:0]]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    exp_ready = (!rst && !pend && !clr && found) ? 4'(1 << win) : 4'h0;
    exp_rsp   = pend && (cyc == acc_cyc + 2) && !rst;

    obs_ready     = req_ready;
    obs_rsp_valid = rsp_valid;
    obs_id        = rsp_id;
    obs_count     = count;
    obs_rsp_count = rsp_count;
    obs_wrap      = wrap;

    chk("ready", 32'(req_ready), 32'(exp_ready));
    chk("count", 32'(count), m_count);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp) begin
      chk("rsp_id", 32'(rsp_id), p_id);
      chk("rsp_count", 32'(rsp_count), p_count);
      chk("wrap", 32'(wrap), 32'(p_wrap));
    end else begin
      chk("wrap_quiet", 32'(wrap), 0);
    end

    if (rst) begin
      m_count = 0;
      m_ptr   = 0;
      pend    = 1'b0;
    end else if (!pend) begin
      if (clr) begin
        m_count = 0;
      end else if (found) begin
        pend    = 1'b1;
        acc_cyc = cyc;
        p_id    = win;
        opc     = (int'(op) >> (2 * win)) & 3;
        dat     = (int'(d) >> (W * win)) & (MODV - 1);
        case (opc)
          1: begin p_count = (m_count + 1) % MODV;        p_wrap = (m_count == MODV - 1); end
          2: begin p_count = (m_count + MODV - 1) % MODV; p_wrap = (m_count == 0);        end
          3: begin p_count = dat;                         p_wrap = 1'b0;                  end
          default: begin p_count = m_count;               p_wrap = 1'b0;                  end
        endcase
      end
    end
    cyc++;
  endtask

  task automatic idle2();
    step(1'b0, 1'b0, 4'h0, 8'h00, 16'h0000);
    step(1'b0, 1'b0, 4'h0, 8'h00, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; req_valid = '0; req_op = '0; req_data = '0;
    m_count = 0; m_ptr = 0; cyc = 0; acc_cyc = 0; p_id = 0; p_count = 0;
    pend = 1'b0; p_wrap = 1'b0;
    repeat (2) @(posedge clk);

    // reset held with everything requesting
    step(1'b1, 1'b0, 4'hF, 8'h55, 16'h0000);
    chk("rst_ready", 32'(obs_ready), 0);
    chk("rst_rsp_valid", 32'(obs_rsp_valid), 0);
    chk("rst_rsp_id", 32'(obs_id), 0);
    chk("rst_rsp_count", 32'(obs_rsp_count), 0);
    chk("rst_count", 32'(obs_count), 0);

    // requester 2 INC
    step(1'b0, 1'b0, 4'b0100, 8'b00_01_00_00, 16'h0000);
    chk("d034_ready", 32'(obs_ready), 32'h4);
    idle2();
    chk("d034_rsp_valid", 32'(obs_rsp_valid), 1);
    chk("d034_rsp_id", 32'(obs_id), 2);
    chk("d034_rsp_count", 32'(obs_rsp_count), 1);
    chk("d034_wrap", 32'(obs_wrap), 0);

    // LOAD F, INC overflow, DEC underflow
    step(1'b0, 1'b0, 4'b0001, 8'b00_00_00_11, 16'h000F);
    idle2();
    chk("d035_load", 32'(obs_rsp_count), 32'hF);
    step(1'b0, 1'b0, 4'b0010, 8'b00_00_01_00, 16'h0000);
    idle2();
    chk("d035_inc_id", 32'(obs_id), 1);
    chk("d035_inc_count", 32'(obs_rsp_count), 0);
    chk("d035_inc_wrap", 32'(obs_wrap), 1);
    step(1'b0, 1'b0, 4'b1000, 8'b10_00_00_00, 16'h0000);
    idle2();
    chk("d035_dec_id", 32'(obs_id), 3);
    chk("d035_dec_count", 32'(obs_rsp_count), 32'hF);
    chk("d035_dec_wrap", 32'(obs_wrap), 1);

    // clear during EXEC/RESP ignored, honoured once back in IDLE
    step(1'b0, 1'b0, 4'b0010, 8'b00_00_11_00, 16'h0090);
    step(1'b0, 1'b1, 4'h0, 8'h00, 16'h0000);
    step(1'b0, 1'b1, 4'h0, 8'h00, 16'h0000);
    chk("d037_rsp_count", 32'(obs_rsp_count), 9);
    step(1'b0, 1'b1, 4'hF, 8'h55, 16'h0000);
    chk("d037_no_grant", 32'(obs_ready), 0);
    step(1'b0, 1'b0, 4'h0, 8'h00, 16'h0000);
    chk("d037_cleared", 32'(obs_count), 0);

    // all requesters INC continuously from 0
    step(1'b1, 1'b0, 4'h0, 8'h00, 16'h0000);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b0, 4'hF, 8'h55, 16'h0000);
      if (k % 3 == 0) chk("d036_grant", 32'(obs_ready), 32'(1 << ((k / 3) % N)));
      if (k % 3 == 2) begin
        chk("d036_rsp_id", 32'(obs_id), (k / 3) % N);
        chk("d036_rsp_count", 32'(obs_rsp_count), k / 3 + 1);
      end
    end

    // reset in EXEC of INC at count 5
    step(1'b0, 1'b0, 4'b0100, 8'b00_01_00_00, 16'h0000);
    step(1'b1, 1'b0, 4'h0, 8'h00, 16'h0000);
    step(1'b0, 1'b0, 4'hF, 8'h55, 16'h0000);
    chk("d038_no_rsp", 32'(obs_rsp_valid), 0);
    chk("d038_count", 32'(obs_count), 0);
    chk("d038_grant0", 32'(obs_ready), 32'h1);
    idle2();

    // requester 1 present only while requester 0 wins
    step(1'b0, 1'b0, 4'b0100, 8'b00_01_00_00, 16'h0000);
    chk("d039_pre_grant", 32'(obs_ready), 32'h4);
    idle2();
    step(1'b0, 1'b0, 4'b0011, 8'h05, 16'h0000);
    chk("d039_grant0", 32'(obs_ready), 32'h1);
    idle2();
    chk("d039_rsp_id", 32'(obs_id), 0);
    step(1'b0, 1'b0, 4'b0011, 8'h05, 16'h0000);
    chk("d039_ptr1", 32'(obs_ready), 32'h2);
    idle2();

    for (int t = 0; t < 600; t++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           4'($urandom), 8'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
